dcache_refill_ctrl: RTL and testbench
=====================================

DCACHE_REFILL_CTRL -- requirements
Module: dcache_refill_ctrl

Interface
REQ-001 SHALL have parameter INIT_SWEEP, default 1; 1 = clear all 256 tags after reset, 0 = skip sweep.
REQ-002 SHALL have one clock and a synchronous active-high reset: clk, rst.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid_i/req_ready_o  in/out  1/1  miss request handshake.
REQ-006 req_addr_i  in  28  miss line address [31:4].
REQ-007 req_wb_i  in  1  victim dirty, write back first; req_victim_tag_i  in  22  victim tag.
REQ-008 rd_req_valid_o/rd_req_ready_i  out/in  1/1, rd_addr_o  out  32  bus read request.
REQ-009 rd_data_valid_i  in  1, rd_data_i  in  32, rd_last_i  in  1  bus read beats.
REQ-010 wr_req_valid_o/wr_req_ready_i  out/in  1/1, wr_addr_o  out  32  bus write request.
REQ-011 wr_data_valid_o/wr_data_ready_i  out/in  1/1, wr_data_o  out  32, wr_last_o  out  1  bus write beats; wr_done_i  in  1  write response.
REQ-012 st_we_i  in  4, st_addr_i  in  10, st_data_i  in  32, st_ready_o  out  1  store-hit write port.
REQ-013 lkp_addr_i  in  10  lookup read address; lkp_stall_o  out  1  read port taken.
REQ-014 ram_data_we_o  out  4, ram_tag_we_o  out  1, ram_r_addr_o  out  10, ram_w_addr_o  out  10, ram_wdata_o  out  32, ram_tag_o  out  22  to way RAMs (addresses are [11:2]).
REQ-015 ram_rdata_i  in  32  data RAM read, 1-cycle latency.
REQ-016 done_o  out  1  refill-complete pulse; err_o  out  1  sticky protocol error.

Function
REQ-017 Tag layout SHALL be [21]=valid, [20]=dirty, [19:0]=addr[31:12]; line = 4 words, index = addr[11:4].
REQ-018 States SHALL be INIT, IDLE, WB_READ, WB_AREQ, WB_DATA, WB_RESP, RF_AREQ, RF_DATA, TAG_WR, DONE.
REQ-019 INIT: 256 cycles, counter i 0..255, ram_tag_we_o=1, ram_w_addr_o={i,2'b00}, ram_tag_o=0; then IDLE.
REQ-020 IDLE: req_ready_o=1, st_ready_o=1; write port passes st_* through; accept on req_valid_i&&req_ready_o, latching address, wb flag, victim tag.
REQ-021 Accept with req_wb_i=1 -> WB_READ; else -> RF_AREQ.
REQ-022 WB_READ: 4 cycles, ram_r_addr_o={idx,k} for k=0..3, lkp_stall_o=1; ram_rdata_i captured one cycle later into 4-word buffer; 5th cycle captures word 3 -> WB_AREQ.
REQ-023 Outside WB_READ, ram_r_addr_o SHALL equal lkp_addr_i combinationally and lkp_stall_o=0.
REQ-024 WB_AREQ: wr_req_valid_o=1, wr_addr_o={victim_tag[19:0],idx,4'h0}; hold until wr_req_ready_i -> WB_DATA.
REQ-025 WB_DATA: stream buffer words 0..3 on wr_data_valid_o; advance only on wr_data_ready_i; wr_last_o=1 on word 3; after it -> WB_RESP.
REQ-026 WB_RESP: wait wr_done_i -> RF_AREQ.
REQ-027 RF_AREQ: rd_req_valid_o=1, rd_addr_o={addr[31:4],4'h0}; hold until rd_req_ready_i -> RF_DATA.
REQ-028 RF_DATA: each rd_data_valid_i beat b (0..3, internal counter) SHALL write ram_data_we_o=4'hF, ram_w_addr_o={idx,b}, ram_wdata_o=rd_data_i in the same cycle; after beat 3 -> TAG_WR.
REQ-029 rd_last_i mismatch with beat 3 SHALL set err_o; sequencing uses internal counter only.
REQ-030 TAG_WR: one cycle, ram_tag_we_o=1, ram_w_addr_o={idx,2'b00}, ram_tag_o={1'b1,1'b0,addr[31:12]} -> DONE.
REQ-031 DONE: done_o=1 one cycle -> IDLE.
REQ-032 Outside IDLE: st_ready_o=0, st_we_i ignored; ram_data_we_o=0 except RF_DATA beats.
REQ-033 All bus valids SHALL be 0 outside their owning state; no new request accepted in DONE.

Reset
REQ-034 rst SHALL force state INIT (IDLE if INIT_SWEEP=0), counters 0, err_o=0, done_o=0, all bus valids 0, all RAM write enables 0 next cycle.
REQ-035 rst mid-transaction SHALL abandon it with no further RAM or bus writes; sweep restarts.

Verification
REQ-036 Reset, INIT_SWEEP=1 -> 256 tag writes to indices 0..255 with tag 0, req_ready_o=1 at cycle 257.
REQ-037 Clean miss addr 0x8000_1230 -> rd_addr_o=0x8000_1230; 4 beats to w_addr 0x8C..0x8F; tag 0x280001 at index 0x23; done_o one cycle.
REQ-038 Dirty miss, victim tag 0x3_00055 -> lkp_stall_o 4 cycles, wr_addr_o=0x0005_5230, 4 buffered words in order, wr_last_o on 4th, refill after wr_done_i.
REQ-039 wr_data_ready_i toggling 1,0,0,1 -> no word duplicated or skipped.
REQ-040 rd_last_i asserted on beat 2 -> err_o=1, still 4 writes, completes normally.
REQ-041 rst asserted in RF_DATA after beat 1 -> no further data/tag writes except sweep; done_o never pulses.

Source files
------------

// File: rtl/dcache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_refill_ctrl_if
// Description : Bundles every handshake, bus and RAM-side signal of the
//               data-cache refill controller. Member suffixes are written from
//               the controller's point of view: _i = into the controller,
//               _o = driven by the controller.
//   Groups:
//     req_*   miss request from the cache pipeline (valid/ready)
//     rd_*    bus read request + read data beats
//     wr_*    bus write request + write data beats + write response
//     st_*    store-hit write port, forwarded to the data RAM while idle
//     lkp_*   lookup read address and read-port stall indication
//     ram_*   data/tag way-RAM write and read ports
//     done_o / err_o  completion pulse and sticky protocol error
//   Modports:
//     master  the refill controller
//     slave   the environment (cache pipeline, bus, RAMs)
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_refill_ctrl_if;
    // Miss request
    logic        req_valid_i;
    logic        req_ready_o;
    logic [27:0] req_addr_i;
    logic        req_wb_i;
    logic [21:0] req_victim_tag_i;

    // Bus read channel
    logic        rd_req_valid_o;
    logic        rd_req_ready_i;
    logic [31:0] rd_addr_o;
    logic        rd_data_valid_i;
    logic [31:0] rd_data_i;
    logic        rd_last_i;

    // Bus write channel
    logic        wr_req_valid_o;
    logic        wr_req_ready_i;
    logic [31:0] wr_addr_o;
    logic        wr_data_valid_o;
    logic        wr_data_ready_i;
    logic [31:0] wr_data_o;
    logic        wr_last_o;
    logic        wr_done_i;

    // Store-hit write port
    logic [3:0]  st_we_i;
    logic [9:0]  st_addr_i;
    logic [31:0] st_data_i;
    logic        st_ready_o;

    // Lookup read port
    logic [9:0]  lkp_addr_i;
    logic        lkp_stall_o;

    // Way RAMs
    logic [3:0]  ram_data_we_o;
    logic        ram_tag_we_o;
    logic [9:0]  ram_r_addr_o;
    logic [9:0]  ram_w_addr_o;
    logic [31:0] ram_wdata_o;
    logic [21:0] ram_tag_o;
    logic [31:0] ram_rdata_i;

    // Status
    logic        done_o;
    logic        err_o;

    modport master (
        input  req_valid_i, req_addr_i, req_wb_i, req_victim_tag_i,
        output req_ready_o,
        output rd_req_valid_o, rd_addr_o,
        input  rd_req_ready_i, rd_data_valid_i, rd_data_i, rd_last_i,
        output wr_req_valid_o, wr_addr_o, wr_data_valid_o, wr_data_o, wr_last_o,
        input  wr_req_ready_i, wr_data_ready_i, wr_done_i,
        input  st_we_i, st_addr_i, st_data_i,
        output st_ready_o,
        input  lkp_addr_i,
        output lkp_stall_o,
        output ram_data_we_o, ram_tag_we_o, ram_r_addr_o, ram_w_addr_o,
        output ram_wdata_o, ram_tag_o,
        input  ram_rdata_i,
        output done_o, err_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_wb_i, req_victim_tag_i,
        input  req_ready_o,
        input  rd_req_valid_o, rd_addr_o,
        output rd_req_ready_i, rd_data_valid_i, rd_data_i, rd_last_i,
        input  wr_req_valid_o, wr_addr_o, wr_data_valid_o, wr_data_o, wr_last_o,
        output wr_req_ready_i, wr_data_ready_i, wr_done_i,
        output st_we_i, st_addr_i, st_data_i,
        input  st_ready_o,
        output lkp_addr_i,
        input  lkp_stall_o,
        input  ram_data_we_o, ram_tag_we_o, ram_r_addr_o, ram_w_addr_o,
        input  ram_wdata_o, ram_tag_o,
        output ram_rdata_i,
        input  done_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/dcache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_refill_ctrl
// Description : Single-way data-cache line refill controller. After reset it
//               optionally clears all 256 tags, then serves miss requests:
//               a dirty victim line (4 words) is read out of the data RAM,
//               written back over the bus, then the missing line is fetched
//               beat by beat straight into the data RAM and its tag written.
//               While idle the store-hit port owns the RAM write port.
//   Ports:
//     clk      rising-edge clock
//     rst      synchronous active-high reset
//     bus      dcache_refill_ctrl_if.master (request, bus read/write,
//              store port, lookup port, way RAMs, done/err status)
//   Parameters:
//     INIT_SWEEP  1 = clear every tag after reset, 0 = start directly idle
//   Tag format: [21] valid, [20] dirty, [19:0] address bits [31:12].
//   RAM word addresses are byte address bits [11:2] = {index, word}.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_refill_ctrl #(
    parameter bit INIT_SWEEP = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    dcache_refill_ctrl_if.master   bus
);

    typedef enum logic [3:0] {
        INIT    = 4'd0,
        IDLE    = 4'd1,
        WB_READ = 4'd2,
        WB_AREQ = 4'd3,
        WB_DATA = 4'd4,
        WB_RESP = 4'd5,
        RF_AREQ = 4'd6,
        RF_DATA = 4'd7,
        TAG_WR  = 4'd8,
        DONE    = 4'd9
    } state_t;

    localparam logic [7:0] SWEEP_LAST = 8'hFF;   // last tag index swept
    localparam logic [7:0] WB_RD_LAST = 8'd4;    // WB_READ capture-only cycle
    localparam logic [1:0] WORD_LAST  = 2'd3;    // last word of a line

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;      // sweep index / word counter
    logic               err_q, err_d;
    logic [27:0]        addr_q, addr_d;    // miss line address [31:4]
    logic               wb_q, wb_d;        // request carried a dirty victim
    logic [21:0]        vtag_q, vtag_d;    // victim tag
    logic [3:0][31:0]   buf_q, buf_d;      // write-back line buffer

    logic [7:0]         idx;
    logic [1:0]         rd_slot;
    logic               unused_vtag;

    assign idx     = addr_q[7:0];
    // Read data arrives one cycle after its address, so the word captured in
    // WB_READ cycle k belongs to slot k-1 (cycle 4 wraps to slot 3).
    assign rd_slot = cnt_q[1:0] - 2'd1;

    // Valid/dirty bits of the victim are not needed to form the write address.
    assign unused_vtag = ^{vtag_q[21:20], wb_q};

    // Control state with synchronous reset; a reset anywhere abandons the
    // transaction and restarts the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT_SWEEP ? INIT : IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Datapath holding registers need no reset: they are always loaded
    // before being consumed.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        wb_q   <= wb_d;
        vtag_q <= vtag_d;
        buf_q  <= buf_d;
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wb_d    = wb_q;
        vtag_d  = vtag_q;
        buf_d   = buf_q;

        bus.req_ready_o     = 1'b0;
        bus.st_ready_o      = 1'b0;
        bus.rd_req_valid_o  = 1'b0;
        bus.rd_addr_o       = {addr_q, 4'h0};
        bus.wr_req_valid_o  = 1'b0;
        bus.wr_addr_o       = {vtag_q[19:0], idx, 4'h0};
        bus.wr_data_valid_o = 1'b0;
        bus.wr_data_o       = buf_q[cnt_q[1:0]];
        bus.wr_last_o       = 1'b0;
        bus.lkp_stall_o     = 1'b0;
        bus.ram_r_addr_o    = bus.lkp_addr_i;
        bus.ram_data_we_o   = 4'h0;
        bus.ram_tag_we_o    = 1'b0;
        bus.ram_w_addr_o    = 10'd0;
        bus.ram_wdata_o     = 32'd0;
        bus.ram_tag_o       = 22'd0;
        bus.done_o          = 1'b0;
        bus.err_o           = err_q;

        unique case (state_q)
            INIT: begin
                bus.ram_tag_we_o = 1'b1;
                bus.ram_w_addr_o = {cnt_q, 2'b00};
                if (cnt_q == SWEEP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            IDLE: begin
                bus.req_ready_o   = 1'b1;
                bus.st_ready_o    = 1'b1;
                bus.ram_data_we_o = bus.st_we_i;
                bus.ram_w_addr_o  = bus.st_addr_i;
                bus.ram_wdata_o   = bus.st_data_i;
                if (bus.req_valid_i) begin
                    addr_d  = bus.req_addr_i;
                    wb_d    = bus.req_wb_i;
                    vtag_d  = bus.req_victim_tag_i;
                    cnt_d   = '0;
                    state_d = bus.req_wb_i ? WB_READ : RF_AREQ;
                end
            end

            // Four address cycles, then one more to capture the last word.
            WB_READ: begin
                if (cnt_q < WB_RD_LAST) begin
                    bus.lkp_stall_o  = 1'b1;
                    bus.ram_r_addr_o = {idx, cnt_q[1:0]};
                end
                if (cnt_q != 8'd0) begin
                    buf_d[rd_slot] = bus.ram_rdata_i;
                end
                if (cnt_q == WB_RD_LAST) begin
                    cnt_d   = '0;
                    state_d = WB_AREQ;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            WB_AREQ: begin
                bus.wr_req_valid_o = 1'b1;
                if (bus.wr_req_ready_i) begin
                    state_d = WB_DATA;
                end
            end

            WB_DATA: begin
                bus.wr_data_valid_o = 1'b1;
                bus.wr_last_o       = (cnt_q[1:0] == WORD_LAST);
                if (bus.wr_data_ready_i) begin
                    if (cnt_q[1:0] == WORD_LAST) begin
                        cnt_d   = '0;
                        state_d = WB_RESP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            WB_RESP: begin
                if (bus.wr_done_i) begin
                    state_d = RF_AREQ;
                end
            end

            RF_AREQ: begin
                bus.rd_req_valid_o = 1'b1;
                if (bus.rd_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = RF_DATA;
                end
            end

            // Beats land in the data RAM in the cycle they arrive. The
            // beat counter alone sequences the line; rd_last_i is only
            // cross-checked against it.
            RF_DATA: begin
                if (bus.rd_data_valid_i) begin
                    bus.ram_data_we_o = 4'hF;
                    bus.ram_w_addr_o  = {idx, cnt_q[1:0]};
                    bus.ram_wdata_o   = bus.rd_data_i;
                    if (bus.rd_last_i != (cnt_q[1:0] == WORD_LAST)) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q[1:0] == WORD_LAST) begin
                        cnt_d   = '0;
                        state_d = TAG_WR;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            TAG_WR: begin
                bus.ram_tag_we_o = 1'b1;
                bus.ram_w_addr_o = {idx, 2'b00};
                bus.ram_tag_o    = {1'b1, 1'b0, addr_q[27:8]};
                state_d          = DONE;
            end

            DONE: begin
                bus.done_o = 1'b1;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_refill_ctrl
// Description : Scoreboard bench for dcache_refill_ctrl. Stimulus tasks push
//               the expected RAM writes, bus addresses/words, tag writes and
//               done pulses into queues; a negedge monitor pops and compares
//               whenever the DUT presents an event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_refill_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_refill_ctrl_if ifc ();

    dcache_refill_ctrl #(.INIT_SWEEP(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Data RAM model: 1-cycle read latency, byte write enables.
    logic [31:0] dmem [1024];
    logic [31:0] rdata_q;
    always @(posedge clk) begin
        rdata_q <= dmem[ifc.ram_r_addr_o];
        for (int b = 0; b < 4; b++)
            if (ifc.ram_data_we_o[b])
                dmem[ifc.ram_w_addr_o][8*b +: 8] <= ifc.ram_wdata_o[8*b +: 8];
    end
    assign ifc.ram_rdata_i = rdata_q;

    // Reference contents of the data array and the scoreboard queues.
    logic [31:0] ref_mem [1024];
    typedef struct packed { logic [3:0] we; logic [9:0] a; logic [31:0] d; } dw_t;
    typedef struct packed { logic [9:0] a; logic [21:0] t; } tw_t;
    dw_t         q_dw[$];
    tw_t         q_tw[$];
    logic [31:0] q_rd[$];
    logic [31:0] q_wa[$];
    logic [32:0] q_wd[$];
    logic [9:0]  q_ra[$];
    int          q_done;
    int          done_seen;
    bit          err_exp;
    int          vec;
    int          miss;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic void tmo(input string nm);
        vec++;
        miss++;
        $display("FAIL %s: timed out, no DUT response within bound", nm);
    endfunction

    function automatic void flush_all();
        q_dw.delete(); q_tw.delete(); q_rd.delete();
        q_wa.delete(); q_wd.delete(); q_ra.delete();
        q_done = 0;
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.lkp_stall_o) begin
                if (q_ra.size() == 0) check("stall_unexp", ifc.lkp_stall_o, 1'b0);
                else                  check("stall_raddr", ifc.ram_r_addr_o, q_ra.pop_front());
            end else begin
                check("lkp_pass", ifc.ram_r_addr_o, ifc.lkp_addr_i);
            end
            if (ifc.ram_data_we_o != 4'd0) begin
                if (q_dw.size() == 0) check("dwr_unexp", ifc.ram_data_we_o, 4'd0);
                else check("dwr", {ifc.ram_data_we_o, ifc.ram_w_addr_o, ifc.ram_wdata_o}, q_dw.pop_front());
            end
            if (ifc.ram_tag_we_o) begin
                if (q_tw.size() == 0) check("tagwr_unexp", ifc.ram_tag_we_o, 1'b0);
                else check("tagwr", {ifc.ram_w_addr_o, ifc.ram_tag_o}, q_tw.pop_front());
            end
            if (ifc.rd_req_valid_o && ifc.rd_req_ready_i) begin
                if (q_rd.size() == 0) check("rdreq_unexp", ifc.rd_req_valid_o, 1'b0);
                else check("rd_addr", ifc.rd_addr_o, q_rd.pop_front());
            end
            if (ifc.wr_req_valid_o && ifc.wr_req_ready_i) begin
                if (q_wa.size() == 0) check("wrreq_unexp", ifc.wr_req_valid_o, 1'b0);
                else check("wr_addr", ifc.wr_addr_o, q_wa.pop_front());
            end
            if (ifc.wr_data_valid_o && ifc.wr_data_ready_i) begin
                if (q_wd.size() == 0) check("wrdata_unexp", ifc.wr_data_valid_o, 1'b0);
                else check("wr_data", {ifc.wr_last_o, ifc.wr_data_o}, q_wd.pop_front());
            end
            if (ifc.done_o) begin
                done_seen++;
                if (q_done == 0) check("done_unexp", ifc.done_o, 1'b0);
                else q_done--;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
        ifc.lkp_addr_i = 10'($urandom);
    endtask

    task automatic wait_sweep();
        int  n   = 0;
        bit  got = 1'b0;
        for (int i = 1; i <= 400 && !got; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("rst_done", ifc.done_o, 1'b0);
                check("rst_err", ifc.err_o, 1'b0);
                check("rst_valids", {ifc.rd_req_valid_o, ifc.wr_req_valid_o, ifc.wr_data_valid_o}, 3'b000);
                check("rst_dwe", ifc.ram_data_we_o, 4'h0);
            end
            if (ifc.req_ready_o) begin
                got = 1'b1;
                n   = i;
            end
        end
        if (!got) tmo("sweep_ready");
        else      check("ready_cycle", n, 257);
        check("sweep_left", q_tw.size(), 0);
        step();
    endtask

    task automatic apply_reset();
        rst                 = 1'b1;
        ifc.req_valid_i     = 1'b0;
        ifc.st_we_i         = 4'h0;
        ifc.rd_req_ready_i  = 1'b0;
        ifc.rd_data_valid_i = 1'b0;
        ifc.rd_last_i       = 1'b0;
        ifc.wr_req_ready_i  = 1'b0;
        ifc.wr_data_ready_i = 1'b0;
        ifc.wr_done_i       = 1'b0;
        flush_all();
        err_exp = 1'b0;
        for (int i = 0; i < 256; i++) q_tw.push_back({8'(i), 2'b00, 22'd0});
        step();
        rst = 1'b0;
        wait_sweep();
    endtask

    task automatic do_store(input logic [3:0] we, input logic [9:0] a, input logic [31:0] d);
        ifc.st_we_i   = we;
        ifc.st_addr_i = a;
        ifc.st_data_i = d;
        q_dw.push_back({we, a, d});
        for (int b = 0; b < 4; b++)
            if (we[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        @(negedge clk);
        check("st_ready", ifc.st_ready_o, 1'b1);
        step();
        ifc.st_we_i = 4'h0;
    endtask

    task automatic do_miss(input logic [27:0] addr, input bit wb, input logic [21:0] vtag,
                           input int last_beat, input int abort_beat, input bit pat);
        logic [7:0]  idx = addr[7:0];
        logic [31:0] d [4];
        logic [3:0]  pb  = 4'b1001;
        bit          hs;
        int          cnt;
        int          n;

        for (int k = 0; k < 4; k++) d[k] = $urandom;
        if (wb) begin
            for (int k = 0; k < 4; k++) begin
                q_ra.push_back({idx, 2'(k)});
                q_wd.push_back({(k == 3), ref_mem[{idx, 2'(k)}]});
            end
            q_wa.push_back({vtag[19:0], idx, 4'h0});
        end
        q_rd.push_back({addr, 4'h0});

        // Request handshake
        ifc.req_valid_i      = 1'b1;
        ifc.req_addr_i       = addr;
        ifc.req_wb_i         = wb;
        ifc.req_victim_tag_i = vtag;
        hs = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk);
            hs = ifc.req_ready_o;
            step();
        end
        ifc.req_valid_i = 1'b0;
        if (!hs) begin tmo("req_accept"); return; end

        // Store traffic while busy must never reach the RAM.
        ifc.st_we_i   = 4'hF;
        ifc.st_addr_i = 10'($urandom);
        ifc.st_data_i = $urandom;

        if (wb) begin
            hs = 1'b0;
            for (int i = 0; i < 50 && !hs; i++) begin
                ifc.wr_req_ready_i = 1'($urandom);
                @(negedge clk);
                hs = ifc.wr_req_valid_o && ifc.wr_req_ready_i;
                step();
            end
            ifc.wr_req_ready_i = 1'b0;
            if (!hs) tmo("wr_req");
            cnt = 0;
            for (int i = 0; i < 60 && cnt < 4; i++) begin
                ifc.wr_data_ready_i = pat ? pb[i % 4] : 1'($urandom);
                @(negedge clk);
                if (ifc.wr_data_valid_o && ifc.wr_data_ready_i) cnt++;
                step();
            end
            ifc.wr_data_ready_i = 1'b0;
            if (cnt < 4) tmo("wr_data");
            repeat ($urandom_range(0, 2)) step();
            ifc.wr_done_i = 1'b1;
            step();
            ifc.wr_done_i = 1'b0;
        end

        hs = 1'b0;
        for (int i = 0; i < 50 && !hs; i++) begin
            ifc.rd_req_ready_i = 1'($urandom);
            @(negedge clk);
            hs = ifc.rd_req_valid_o && ifc.rd_req_ready_i;
            step();
        end
        ifc.rd_req_ready_i = 1'b0;
        if (!hs) tmo("rd_req");

        for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(0, 2)) step();
            ifc.rd_data_valid_i = 1'b1;
            ifc.rd_data_i       = d[b];
            ifc.rd_last_i       = (b == last_beat);
            q_dw.push_back({4'hF, idx, 2'(b), d[b]});
            ref_mem[{idx, 2'(b)}] = d[b];
            step();
            ifc.rd_data_valid_i = 1'b0;
            ifc.rd_last_i       = 1'b0;
            if (b == abort_beat) begin
                apply_reset();
                return;
            end
        end
        if (last_beat != 3) err_exp = 1'b1;
        q_tw.push_back({idx, 2'b00, 1'b1, 1'b0, addr[27:8]});
        q_done++;

        n = done_seen;
        for (int i = 0; i < 20 && done_seen == n; i++) step();
        ifc.st_we_i = 4'h0;
        if (done_seen == n) tmo("done");
        check("err", ifc.err_o, err_exp);
        check("q_empty", q_dw.size() + q_tw.size() + q_rd.size() + q_wa.size()
                         + q_wd.size() + q_ra.size() + q_done, 0);
    endtask

    initial begin
        vec = 0; miss = 0; q_done = 0; done_seen = 0; err_exp = 1'b0;
        ifc.req_valid_i = 1'b0; ifc.req_addr_i = '0; ifc.req_wb_i = 1'b0; ifc.req_victim_tag_i = '0;
        ifc.rd_req_ready_i = 1'b0; ifc.rd_data_valid_i = 1'b0; ifc.rd_data_i = '0; ifc.rd_last_i = 1'b0;
        ifc.wr_req_ready_i = 1'b0; ifc.wr_data_ready_i = 1'b0; ifc.wr_done_i = 1'b0;
        ifc.st_we_i = 4'h0; ifc.st_addr_i = '0; ifc.st_data_i = '0; ifc.lkp_addr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        apply_reset();

        for (int i = 0; i < 1024; i++) do_store(4'hF, 10'(i), $urandom);

        do_miss(28'h8000123, 1'b0, 22'h0, 3, -1, 1'b0);
        do_store(4'b0101, 10'h08D, $urandom);
        do_miss(28'h8000123, 1'b1, 22'h300055, 3, -1, 1'b1);
        do_miss(28'($urandom), 1'b0, 22'h0, 2, -1, 1'b0);

        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_store(4'($urandom_range(1, 15)), 10'($urandom), $urandom);
            do_miss(28'($urandom), 1'($urandom), 22'($urandom), 3, -1, 1'($urandom));
        end

        do_miss(28'($urandom), 1'($urandom), 22'($urandom), 3, 1, 1'b0);
        do_miss(28'($urandom), 1'b1, 22'($urandom), 3, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", miss);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
